// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared combinational ALU.
//   i_clk, i_rst                : clock (rising edge), synchronous active-high reset
//   i_req_*_0 / i_req_*_1       : valid/ready operation requests (operands A/B, 3-bit function)
//   o_req_ready_0 / _1          : request accepted this cycle (combinational from valids)
//   o_rsp_valid_0 / _1, i_rsp_ready_0 / _1 : per-requester response handshake
//   o_rsp_y, o_rsp_err          : shared result and reserved-code flag
//   o_alu_a/b/f, i_alu_y        : registered ALU operands/function and ALU result
//   o_busy                      : controller not idle
module alu_arbiter #(
    parameter int unsigned BW_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid_0,
    output logic               o_req_ready_0,
    input  logic [BW_DATA-1:0] i_req_a_0,
    input  logic [BW_DATA-1:0] i_req_b_0,
    input  logic [2:0]         i_req_f_0,
    input  logic               i_req_valid_1,
    output logic               o_req_ready_1,
    input  logic [BW_DATA-1:0] i_req_a_1,
    input  logic [BW_DATA-1:0] i_req_b_1,
    input  logic [2:0]         i_req_f_1,
    output logic               o_rsp_valid_0,
    input  logic               i_rsp_ready_0,
    output logic               o_rsp_valid_1,
    input  logic               i_rsp_ready_1,
    output logic [BW_DATA-1:0] o_rsp_y,
    output logic               o_rsp_err,
    output logic [BW_DATA-1:0] o_alu_a,
    output logic [BW_DATA-1:0] o_alu_b,
    output logic [2:0]         o_alu_f,
    input  logic [BW_DATA-1:0] i_alu_y,
    output logic               o_busy
);

    localparam logic [2:0] F_RESERVED = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;      // requester granted most recently
    logic   owner;     // requester that owns the in-flight operation
    logic   grant;     // requester that would win in IDLE this cycle
    logic   accept;
    logic   rsp_taken;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (i_req_valid_0 && i_req_valid_1) begin
            grant = ~last;
        end else if (i_req_valid_1) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (i_req_valid_0 || i_req_valid_1);
    assign rsp_taken = owner ? i_rsp_ready_1 : i_rsp_ready_0;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_taken) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state and owner.
    always_comb begin
        o_req_ready_0 = 1'b0;
        o_req_ready_1 = 1'b0;
        o_rsp_valid_0 = 1'b0;
        o_rsp_valid_1 = 1'b0;
        o_busy        = (state != IDLE);
        if (state == IDLE) begin
            o_req_ready_0 = i_req_valid_0 && !grant;
            o_req_ready_1 = i_req_valid_1 && grant;
        end
        if (state == RESP) begin
            o_rsp_valid_0 = !owner;
            o_rsp_valid_1 = owner;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_f   <= '0;
            o_rsp_y   <= '0;
            o_rsp_err <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
        end else begin
            if (accept) begin
                o_alu_a <= grant ? i_req_a_1 : i_req_a_0;
                o_alu_b <= grant ? i_req_b_1 : i_req_b_0;
                o_alu_f <= grant ? i_req_f_1 : i_req_f_0;
                owner   <= grant;
                last    <= grant;
            end
            if (state == EXEC) begin
                // The reserved code returns zero with the error flag, whatever the ALU drives.
                o_rsp_err <= (o_alu_f == F_RESERVED);
                o_rsp_y   <= (o_alu_f == F_RESERVED) ? '0 : i_alu_y;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    localparam int unsigned BW_DATA = 32;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_req_valid_0, i_req_valid_1;
    logic               o_req_ready_0, o_req_ready_1;
    logic [BW_DATA-1:0] i_req_a_0, i_req_b_0, i_req_a_1, i_req_b_1;
    logic [2:0]         i_req_f_0, i_req_f_1;
    logic               o_rsp_valid_0, o_rsp_valid_1;
    logic               i_rsp_ready_0, i_rsp_ready_1;
    logic [BW_DATA-1:0] o_rsp_y;
    logic               o_rsp_err;
    logic [BW_DATA-1:0] o_alu_a, o_alu_b;
    logic [2:0]         o_alu_f;
    logic [BW_DATA-1:0] i_alu_y;
    logic               o_busy;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_arbiter #(.BW_DATA(BW_DATA)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid_0 (i_req_valid_0),
        .o_req_ready_0 (o_req_ready_0),
        .i_req_a_0     (i_req_a_0),
        .i_req_b_0     (i_req_b_0),
        .i_req_f_0     (i_req_f_0),
        .i_req_valid_1 (i_req_valid_1),
        .o_req_ready_1 (o_req_ready_1),
        .i_req_a_1     (i_req_a_1),
        .i_req_b_1     (i_req_b_1),
        .i_req_f_1     (i_req_f_1),
        .o_rsp_valid_0 (o_rsp_valid_0),
        .i_rsp_ready_0 (i_rsp_ready_0),
        .o_rsp_valid_1 (o_rsp_valid_1),
        .i_rsp_ready_1 (i_rsp_ready_1),
        .o_rsp_y       (o_rsp_y),
        .o_rsp_err     (o_rsp_err),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_f       (o_alu_f),
        .i_alu_y       (i_alu_y),
        .o_busy        (o_busy)
    );

    // External ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; anything else drives junk.
    always_comb begin
        case (o_alu_f)
            3'b000:  i_alu_y = o_alu_a & o_alu_b;
            3'b001:  i_alu_y = o_alu_a | o_alu_b;
            3'b010:  i_alu_y = o_alu_a + o_alu_b;
            3'b110:  i_alu_y = o_alu_a - o_alu_b;
            3'b111:  i_alu_y = BW_DATA'(($signed(o_alu_a) < $signed(o_alu_b)) ? 1 : 0);
            default: i_alu_y = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and let combinational paths settle.
    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g;
        int grants;

        i_rst = 1'b1;
        i_req_valid_0 = 1'b0; i_req_a_0 = '0; i_req_b_0 = '0; i_req_f_0 = '0;
        i_req_valid_1 = 1'b0; i_req_a_1 = '0; i_req_b_1 = '0; i_req_f_1 = '0;
        i_rsp_ready_0 = 1'b0; i_rsp_ready_1 = 1'b0;
        step();
        step();

        // Reset state.
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_alu_a", o_alu_a, 32'd0);
        chk("rst_alu_f", 32'(o_alu_f), 32'd0);
        chk("rst_rsp_y", o_rsp_y, 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst_rsp_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd0);
        i_rst = 1'b0;
        step();

        // Single ADD 5+7 from requester 0.
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd5; i_req_b_0 = 32'd7; i_req_f_0 = 3'b010;
        i_rsp_ready_0 = 1'b1; i_rsp_ready_1 = 1'b1;
        #1;
        chk("add_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd1);
        step();
        i_req_valid_0 = 1'b0;
        #1;
        chk("add_alu_f", 32'(o_alu_f), 32'd2);
        chk("add_alu_a", o_alu_a, 32'd5);
        chk("add_busy_exec", 32'(o_busy), 32'd1);
        chk("add_no_early_valid", 32'(o_rsp_valid_0), 32'd0);
        step();
        chk("add_rsp_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd1);
        chk("add_rsp_y", o_rsp_y, 32'd12);
        chk("add_rsp_err", 32'(o_rsp_err), 32'd0);
        step();
        chk("add_busy_clear", 32'(o_busy), 32'd0);
        chk("add_valid_clear", 32'(o_rsp_valid_0), 32'd0);

        // Simultaneous requests right after reset: requester 0 wins the tie.
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'h0000_F0F0; i_req_b_0 = 32'h0000_0FF0; i_req_f_0 = 3'b000;
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'd3; i_req_b_1 = 32'd5; i_req_f_1 = 3'b111;
        #1;
        chk("tie_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd1);
        step();
        i_req_valid_0 = 1'b0;
        #1;
        chk("tie_exec_ready1", 32'(o_req_ready_1), 32'd0);
        step();
        chk("tie_and_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd1);
        chk("tie_and_y", o_rsp_y, 32'h0000_00F0);
        step();
        chk("tie_req1_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd2);
        step();
        i_req_valid_1 = 1'b0;
        step();
        chk("tie_slt_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd2);
        chk("tie_slt_y", o_rsp_y, 32'd1);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        i_req_valid_0 = 1'b1;
        i_req_valid_1 = 1'b1;
        exp_g  = 0;
        grants = 0;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            step();
            if (o_req_ready_0 || o_req_ready_1) begin
                chk("alt_grant", {30'd0, o_req_ready_1, o_req_ready_0}, (exp_g == 0) ? 32'd1 : 32'd2);
                exp_g = 1 - exp_g;
                grants++;
            end
        end
        chk("alt_grant_count", 32'(grants), 32'd4);
        step();
        i_req_valid_0 = 1'b0;
        i_req_valid_1 = 1'b0;
        step();
        step();

        // Reserved function code from requester 1.
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'd1; i_req_b_1 = 32'd1; i_req_f_1 = 3'b011;
        #1;
        chk("rsv_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd2);
        step();
        i_req_valid_1 = 1'b0;
        step();
        chk("rsv_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd2);
        chk("rsv_err", 32'(o_rsp_err), 32'd1);
        chk("rsv_y", o_rsp_y, 32'd0);
        step();

        // Backpressure: SUB 10-3 held for 5 cycles while requester 1 waits.
        i_rsp_ready_0 = 1'b0;
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd10; i_req_b_0 = 32'd3; i_req_f_0 = 3'b110;
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'd1; i_req_b_1 = 32'd2; i_req_f_1 = 3'b001;
        #1;
        chk("bp_ready0", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd1);
        step();
        i_req_valid_0 = 1'b0;
        #1;
        chk("bp_exec_ready1", 32'(o_req_ready_1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd1);
            chk("bp_hold_y", o_rsp_y, 32'd7);
            chk("bp_hold_ready1", 32'(o_req_ready_1), 32'd0);
        end
        i_rsp_ready_0 = 1'b1;
        step();
        chk("bp_req1_after", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd2);
        chk("bp_valid_dropped", 32'(o_rsp_valid_0), 32'd0);
        step();
        i_req_valid_1 = 1'b0;
        step();
        chk("bp_or_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd2);
        chk("bp_or_y", o_rsp_y, 32'd3);
        step();

        // Reset during EXEC of ADD 1+1 drops the result.
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'd1; i_req_b_0 = 32'd1; i_req_f_0 = 3'b010;
        #1;
        chk("mid_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd1);
        step();
        i_req_valid_0 = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("mid_busy_exec", 32'(o_busy), 32'd1);
        step();
        i_rst = 1'b0;
        chk("mid_rst_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_alu_a", o_alu_a, 32'd0);
        chk("mid_rst_alu_f", 32'(o_alu_f), 32'd0);
        chk("mid_rst_y", o_rsp_y, 32'd0);
        step();
        chk("mid_still_no_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd0);

        // After reset the pointer favours requester 0 again; ADD wraps to zero.
        i_req_valid_0 = 1'b1; i_req_a_0 = 32'hFFFF_FFFF; i_req_b_0 = 32'd1; i_req_f_0 = 3'b010;
        i_req_valid_1 = 1'b1; i_req_a_1 = 32'd6; i_req_b_1 = 32'd2; i_req_f_1 = 3'b110;
        #1;
        chk("wrap_ready0", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd1);
        step();
        i_req_valid_0 = 1'b0;
        step();
        chk("wrap_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd1);
        chk("wrap_y", o_rsp_y, 32'd0);
        chk("wrap_err", 32'(o_rsp_err), 32'd0);
        step();
        chk("wrap_req1_ready", {30'd0, o_req_ready_1, o_req_ready_0}, 32'd2);
        step();
        i_req_valid_1 = 1'b0;
        step();
        chk("wrap_sub_valid", {30'd0, o_rsp_valid_1, o_rsp_valid_0}, 32'd2);
        chk("wrap_sub_y", o_rsp_y, 32'd4);
        step();
        chk("end_idle", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester controller that time-shares one combinational ALU (BW_DATA operands, 3-bit function code).
- Accepts operation requests on two valid/ready ports and arbitrates between them round-robin.
- Registers operands and function code onto the ALU inputs, captures the ALU result, and returns it to the winning requester on a valid/ready response port.
- Sits between the ALU and its consumers. The ALU instance stays outside this block.

Parameters:
BW_DATA, 32, operand/result width; must match the attached ALU.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous, active-high reset.
i_req_valid_0  input  1  requester 0 has an operation.
o_req_ready_0  output  1  requester 0 operation accepted this cycle.
i_req_a_0  input  BW_DATA  requester 0 operand A.
i_req_b_0  input  BW_DATA  requester 0 operand B.
i_req_f_0  input  3  requester 0 function code.
i_req_valid_1, o_req_ready_1, i_req_a_1, i_req_b_1, i_req_f_1: same as requester 0, for requester 1.
o_rsp_valid_0  output  1  result for requester 0 available.
i_rsp_ready_0  input  1  requester 0 takes result.
o_rsp_valid_1  output  1  result for requester 1 available.
i_rsp_ready_1  input  1  requester 1 takes result.
o_rsp_y  output  BW_DATA  result, shared by both response ports.
o_rsp_err  output  1  result is for reserved code 3'b011.
o_alu_a  output  BW_DATA  to ALU i_a.
o_alu_b  output  BW_DATA  to ALU i_b.
o_alu_f  output  3  to ALU i_f.
i_alu_y  input  BW_DATA  from ALU o_y.
o_busy  output  1  state != IDLE.

Behaviour:
- Reset: i_rst sampled high resets every register. State=IDLE. o_alu_a/b/f=0, o_rsp_y=0, o_rsp_err=0, o_rsp_valid_*=0, o_busy=0. Round-robin pointer last=1, so requester 0 wins the first tie.
- State machine (IDLE -> EXEC -> RESP -> IDLE):
  - IDLE: grant = the only valid requester. If both are valid, grant = the requester != last.
  - o_req_ready_k = (state==IDLE) & i_req_valid_k & (grant==k). Ready is combinational from the valid inputs; at most one ready is high per cycle.
  - On accept: register o_alu_a/b/f from the granted port, record owner=k, set last=k, go to EXEC.
  - EXEC (1 cycle): ALU settles. At the clock edge, o_rsp_y <= i_alu_y and o_rsp_err <= (o_alu_f==3'b011). If o_alu_f==3'b011, o_rsp_y <= 0 instead. Go to RESP.
  - RESP: o_rsp_valid_owner=1 and the other o_rsp_valid=0. Hold o_rsp_y/o_rsp_err stable until i_rsp_ready_owner=1, then go to IDLE. i_rsp_ready of the non-owner is ignored.
- Latency and throughput:
  - Accept at edge N; o_rsp_valid rises after edge N+1, i.e. visible in cycle N+1..N+2 window. Concretely: visible in the cycle after the EXEC capture edge.
  - With immediate rsp_ready, a new accept is possible 3 cycles after the previous one.
- o_alu_a/b/f hold their last values outside EXEC; they change only on accept.
- Pending and incoming requests:
  - A requester not granted must keep valid/operands stable; it is served on the next IDLE.
  - Requests arriving during EXEC/RESP are not accepted (ready=0) until the return to IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,…
- Width rules: operands, results and arithmetic are BW_DATA wide (ADD/SUB wrap modulo 2^BW_DATA), as produced by the ALU. The controller does no arithmetic.
- Reset mid-operation (in EXEC or RESP): next state is IDLE. The in-flight result is dropped, o_rsp_valid_*=0 from the following cycle, and last=1 again.
- A response held in RESP under backpressure blocks all new accepts. No response is ever lost or duplicated.

Test Plan:
- Single ADD: req0 a=5, b=7, f=3'b010, rsp_ready=1.
  -> o_alu_f=3'b010 the cycle after accept.
  -> o_rsp_valid_0=1, o_rsp_y=12, o_rsp_err=0 exactly 2 cycles after accept.
  -> busy then clears.
- Simultaneous requests after reset:
  - req0 AND a=0xF0F0, b=0x0FF0.
  - req1 SLT a=3, b=5.
  - -> req0 served first with y=0x000000F0, then req1 with y=1.
  - -> 4 continuous alternating requests grant 0,1,0,1.
- Reserved code: req1 f=3'b011, a=1, b=1 -> o_rsp_valid_1=1, o_rsp_err=1, o_rsp_y=0.
- Backpressure:
  - Stimulus: req0 SUB a=10, b=3 with i_rsp_ready_0=0 for 5 cycles; req1 valid throughout.
  - -> o_rsp_y=7 stable and o_rsp_valid_0=1 for all 5 cycles.
  - -> o_req_ready_1=0 throughout.
  - -> req1 accepted the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert i_rst in the EXEC cycle of an ADD 1+1.
  - -> no o_rsp_valid ever asserted for it.
  - -> all outputs at reset values next cycle.
  - -> next request is served normally.
- Wrap: ADD a=0xFFFFFFFF, b=1 -> o_rsp_y=0.
